// File: rtl/id_ex_seg_reg_pkg.sv
// Shared constants and the control-field bundle for the ID/EX segment register.
package id_ex_seg_reg_pkg;

  localparam int unsigned REGWRITE_W   = 3;
  localparam int unsigned BRANCHTYPE_W = 3;
  localparam int unsigned ALUCONTRL_W  = 4;

  // Bubble encodings must be all-zero so that a cleared register is a bubble.
  typedef enum logic [REGWRITE_W-1:0] {
    NOREGWRITE = 3'd0,
    LB         = 3'd1,
    LH         = 3'd2,
    LW         = 3'd3,
    LBU        = 3'd4,
    LHU        = 3'd5
  } regwrite_e;

  typedef enum logic [BRANCHTYPE_W-1:0] {
    NOBRANCH = 3'd0,
    BEQ      = 3'd1,
    BNE      = 3'd2,
    BLT      = 3'd3,
    BLTU     = 3'd4,
    BGE      = 3'd5,
    BGEU     = 3'd6
  } branchtype_e;

  typedef struct packed {
    logic                    Jalr;
    logic [REGWRITE_W-1:0]   RegWrite;
    logic                    MemToReg;
    logic [3:0]              MemWrite;
    logic                    LoadNpc;
    logic [1:0]              RegRead;
    logic [BRANCHTYPE_W-1:0] BranchType;
    logic [ALUCONTRL_W-1:0]  AluContrl;
    logic                    AluSrc1;
    logic [1:0]              AluSrc2;
  } ctrl_t;

endpackage

// File: rtl/id_ex_seg_reg_if.sv
// ID-side and EX-side signal bundle of the ID/EX segment register.
interface id_ex_seg_reg_if
  import id_ex_seg_reg_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RA_W  = 5,
  parameter int unsigned CNT_W = 16
);
  logic                    en;
  logic                    clear;

  logic                    ValidD;
  logic [XLEN-1:0]         PCD;
  logic [XLEN-1:0]         ImmD;
  logic [XLEN-1:0]         RegOut1D;
  logic [XLEN-1:0]         RegOut2D;
  logic [RA_W-1:0]         Rs1D;
  logic [RA_W-1:0]         Rs2D;
  logic [RA_W-1:0]         RdD;
  logic                    JalrD;
  logic [REGWRITE_W-1:0]   RegWriteD;
  logic                    MemToRegD;
  logic [3:0]              MemWriteD;
  logic                    LoadNpcD;
  logic [1:0]              RegReadD;
  logic [BRANCHTYPE_W-1:0] BranchTypeD;
  logic [ALUCONTRL_W-1:0]  AluContrlD;
  logic                    AluSrc1D;
  logic [1:0]              AluSrc2D;

  logic                    ValidE;
  logic [XLEN-1:0]         PCE;
  logic [XLEN-1:0]         ImmE;
  logic [XLEN-1:0]         RegOut1E;
  logic [XLEN-1:0]         RegOut2E;
  logic [RA_W-1:0]         Rs1E;
  logic [RA_W-1:0]         Rs2E;
  logic [RA_W-1:0]         RdE;
  logic                    JalrE;
  logic [REGWRITE_W-1:0]   RegWriteE;
  logic                    MemToRegE;
  logic [3:0]              MemWriteE;
  logic                    LoadNpcE;
  logic [1:0]              RegReadE;
  logic [BRANCHTYPE_W-1:0] BranchTypeE;
  logic [ALUCONTRL_W-1:0]  AluContrlE;
  logic                    AluSrc1E;
  logic [1:0]              AluSrc2E;

  logic [CNT_W-1:0]        BubbleCnt;
  logic [CNT_W-1:0]        StallCnt;

  modport master (
    output en, clear,
    output ValidD, PCD, ImmD, RegOut1D, RegOut2D, Rs1D, Rs2D, RdD,
    output JalrD, RegWriteD, MemToRegD, MemWriteD, LoadNpcD, RegReadD,
    output BranchTypeD, AluContrlD, AluSrc1D, AluSrc2D,
    input  ValidE, PCE, ImmE, RegOut1E, RegOut2E, Rs1E, Rs2E, RdE,
    input  JalrE, RegWriteE, MemToRegE, MemWriteE, LoadNpcE, RegReadE,
    input  BranchTypeE, AluContrlE, AluSrc1E, AluSrc2E,
    input  BubbleCnt, StallCnt
  );

  modport slave (
    input  en, clear,
    input  ValidD, PCD, ImmD, RegOut1D, RegOut2D, Rs1D, Rs2D, RdD,
    input  JalrD, RegWriteD, MemToRegD, MemWriteD, LoadNpcD, RegReadD,
    input  BranchTypeD, AluContrlD, AluSrc1D, AluSrc2D,
    output ValidE, PCE, ImmE, RegOut1E, RegOut2E, Rs1E, Rs2E, RdE,
    output JalrE, RegWriteE, MemToRegE, MemWriteE, LoadNpcE, RegReadE,
    output BranchTypeE, AluContrlE, AluSrc1E, AluSrc2E,
    output BubbleCnt, StallCnt
  );
endinterface

// File: rtl/id_ex_seg_reg_field.sv
// Generic pipeline field register: reset > clear (load zero) > en (load d) > hold.
module seg_field_reg #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         CPU_RST,
  input  logic         en,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge CPU_RST) begin
    if (CPU_RST)    q <= '0;
    else if (clear) q <= '0;
    else if (en)    q <= d;
  end
endmodule

// File: rtl/id_ex_seg_reg.sv
// ID/EX segment register with stall/flush, valid flag and bubble/stall counters.
module id_ex_seg_reg
  import id_ex_seg_reg_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RA_W  = 5,
  parameter int unsigned CNT_W = 16
) (
  input logic         clk,
  input logic         CPU_RST,
  id_ex_seg_reg_if.slave bus
);
  localparam int unsigned DATA_W = 1 + 4*XLEN + 3*RA_W;
  localparam int unsigned CTRL_W = $bits(ctrl_t);

  logic [DATA_W-1:0] data_d, data_q;
  ctrl_t             ctrl_d, ctrl_q;
  logic [CNT_W-1:0]  bubble_cnt_d, bubble_cnt_q;
  logic [CNT_W-1:0]  stall_cnt_d, stall_cnt_q;

  assign data_d = {bus.ValidD, bus.PCD, bus.ImmD, bus.RegOut1D, bus.RegOut2D,
                   bus.Rs1D, bus.Rs2D, bus.RdD};
  assign ctrl_d = {bus.JalrD, bus.RegWriteD, bus.MemToRegD, bus.MemWriteD,
                   bus.LoadNpcD, bus.RegReadD, bus.BranchTypeD, bus.AluContrlD,
                   bus.AluSrc1D, bus.AluSrc2D};

  seg_field_reg #(.W(DATA_W)) u_data_reg (
    .clk     (clk),
    .CPU_RST (CPU_RST),
    .en      (bus.en),
    .clear   (bus.clear),
    .d       (data_d),
    .q       (data_q)
  );

  seg_field_reg #(.W(CTRL_W)) u_ctrl_reg (
    .clk     (clk),
    .CPU_RST (CPU_RST),
    .en      (bus.en),
    .clear   (bus.clear),
    .d       (ctrl_d),
    .q       (ctrl_q)
  );

  assign {bus.ValidE, bus.PCE, bus.ImmE, bus.RegOut1E, bus.RegOut2E,
          bus.Rs1E, bus.Rs2E, bus.RdE} = data_q;

  assign bus.JalrE       = ctrl_q.Jalr;
  assign bus.RegWriteE   = ctrl_q.RegWrite;
  assign bus.MemToRegE   = ctrl_q.MemToReg;
  assign bus.MemWriteE   = ctrl_q.MemWrite;
  assign bus.LoadNpcE    = ctrl_q.LoadNpc;
  assign bus.RegReadE    = ctrl_q.RegRead;
  assign bus.BranchTypeE = ctrl_q.BranchType;
  assign bus.AluContrlE  = ctrl_q.AluContrl;
  assign bus.AluSrc1E    = ctrl_q.AluSrc1;
  assign bus.AluSrc2E    = ctrl_q.AluSrc2;

  // A flush during a stall counts only as a bubble, never as a stall cycle.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if (bus.clear)    bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    else if (!bus.en) stall_cnt_d  = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge CPU_RST) begin
    if (CPU_RST) begin
      bubble_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign bus.BubbleCnt = bubble_cnt_q;
  assign bus.StallCnt  = stall_cnt_q;
endmodule

// File: tb/tb_id_ex_seg_reg.sv
// Directed bench for id_ex_seg_reg: reset, pass-through, stall, flush, counter wrap.
module tb_id_ex_seg_reg;
  import id_ex_seg_reg_pkg::*;

  logic clk;
  logic CPU_RST;
  int   n_checks;
  int   n_errors;

  id_ex_seg_reg_if #(.XLEN(32), .RA_W(5), .CNT_W(16)) bus ();
  id_ex_seg_reg_if #(.XLEN(32), .RA_W(5), .CNT_W(4))  bus4 ();

  id_ex_seg_reg #(.XLEN(32), .RA_W(5), .CNT_W(16)) dut (
    .clk     (clk),
    .CPU_RST (CPU_RST),
    .bus     (bus.slave)
  );

  id_ex_seg_reg #(.XLEN(32), .RA_W(5), .CNT_W(4)) dut4 (
    .clk     (clk),
    .CPU_RST (CPU_RST),
    .bus     (bus4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_d();
    bus.ValidD = 0; bus.PCD = '0; bus.ImmD = '0; bus.RegOut1D = '0; bus.RegOut2D = '0;
    bus.Rs1D = '0; bus.Rs2D = '0; bus.RdD = '0; bus.JalrD = 0; bus.RegWriteD = '0;
    bus.MemToRegD = 0; bus.MemWriteD = '0; bus.LoadNpcD = 0; bus.RegReadD = '0;
    bus.BranchTypeD = '0; bus.AluContrlD = '0; bus.AluSrc1D = 0; bus.AluSrc2D = '0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    CPU_RST  = 1'b1;
    bus.en = 1'b1; bus.clear = 1'b0;
    clear_d();
    bus4.en = 1'b1; bus4.clear = 1'b0;
    bus4.ValidD = 0; bus4.PCD = '0; bus4.ImmD = '0; bus4.RegOut1D = '0; bus4.RegOut2D = '0;
    bus4.Rs1D = '0; bus4.Rs2D = '0; bus4.RdD = '0; bus4.JalrD = 0; bus4.RegWriteD = '0;
    bus4.MemToRegD = 0; bus4.MemWriteD = '0; bus4.LoadNpcD = 0; bus4.RegReadD = '0;
    bus4.BranchTypeD = '0; bus4.AluContrlD = '0; bus4.AluSrc1D = 0; bus4.AluSrc2D = '0;
    #12;
    CPU_RST = 1'b0;
    tick();

    // Reset mid-stream: build up non-zero state first, then reset between edges.
    bus.en = 1'b0;
    tick();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0; bus.en = 1'b1;
    bus.ValidD = 1'b1; bus.PCD = 32'h0000_1000; bus.RegWriteD = 3'b101;
    tick();
    check("pre_rst_pc", bus.PCE, 64'h1000);
    check("pre_rst_stall", bus.StallCnt, 64'd1);
    check("pre_rst_bubble", bus.BubbleCnt, 64'd1);
    #2 CPU_RST = 1'b1;
    #1;
    check("rst_pc", bus.PCE, 64'd0);
    check("rst_regwrite", bus.RegWriteE, 64'd0);
    check("rst_valid", bus.ValidE, 64'd0);
    check("rst_bubble", bus.BubbleCnt, 64'd0);
    check("rst_stall", bus.StallCnt, 64'd0);
    @(negedge clk);
    CPU_RST = 1'b0;
    clear_d();
    tick();

    // Pass-through with a one-edge latency.
    bus.ValidD = 1'b1; bus.PCD = 32'h0000_0040; bus.ImmD = 32'hFFFF_FFF0;
    bus.RdD = 5'd5; bus.AluContrlD = 4'd3; bus.MemWriteD = 4'b0011;
    bus.RegOut1D = 32'hDEAD_BEEF; bus.BranchTypeD = 3'd2; bus.AluSrc2D = 2'd2;
    #1;
    check("no_comb_path", bus.PCE, 64'd0);
    tick();
    check("pt_pc", bus.PCE, 64'h40);
    check("pt_imm", bus.ImmE, 64'hFFFF_FFF0);
    check("pt_rd", bus.RdE, 64'd5);
    check("pt_alu", bus.AluContrlE, 64'd3);
    check("pt_memwrite", bus.MemWriteE, 64'h3);
    check("pt_reg1", bus.RegOut1E, 64'hDEAD_BEEF);
    check("pt_branch", bus.BranchTypeE, 64'd2);
    check("pt_alusrc2", bus.AluSrc2E, 64'd2);
    check("pt_valid", bus.ValidE, 64'd1);

    // Stall three edges while D inputs move on.
    bus.en = 1'b0; bus.PCD = 32'h0000_0044; bus.RdD = 5'd9; bus.ImmD = 32'h1;
    repeat (3) tick();
    check("stall_pc", bus.PCE, 64'h40);
    check("stall_imm", bus.ImmE, 64'hFFFF_FFF0);
    check("stall_rd", bus.RdE, 64'd5);
    check("stall_valid", bus.ValidE, 64'd1);
    check("stall_cnt", bus.StallCnt, 64'd3);
    check("stall_bubble", bus.BubbleCnt, 64'd0);

    // Flush overrides a stall.
    bus.clear = 1'b1; bus.RegWriteD = 3'b101; bus.RdD = 5'd7;
    bus.BranchTypeD = 3'd4; bus.MemWriteD = 4'hF;
    tick();
    check("fl_regwrite", bus.RegWriteE, 64'd0);
    check("fl_rd", bus.RdE, 64'd0);
    check("fl_memwrite", bus.MemWriteE, 64'd0);
    check("fl_branch", bus.BranchTypeE, 64'd0);
    check("fl_valid", bus.ValidE, 64'd0);
    check("fl_pc", bus.PCE, 64'd0);
    check("fl_bubble", bus.BubbleCnt, 64'd1);
    check("fl_stall", bus.StallCnt, 64'd3);

    // Stalled bubble stays a bubble.
    bus.clear = 1'b0;
    tick();
    check("sb_valid", bus.ValidE, 64'd0);
    check("sb_rd", bus.RdE, 64'd0);
    check("sb_stall", bus.StallCnt, 64'd4);

    // Load-use bubble then resume.
    bus.clear = 1'b1; bus.en = 1'b1;
    tick();
    check("lu_valid", bus.ValidE, 64'd0);
    check("lu_bubble", bus.BubbleCnt, 64'd2);
    bus.clear = 1'b0; bus.PCD = 32'h0000_0048; bus.ValidD = 1'b1;
    tick();
    check("lu_pc", bus.PCE, 64'h48);
    check("lu_valid2", bus.ValidE, 64'd1);
    check("lu_rd", bus.RdE, 64'd7);
    check("lu_stall", bus.StallCnt, 64'd4);

    // 4-bit counter wrap on the narrow instance.
    check("w_start", bus4.BubbleCnt, 64'd0);
    bus4.clear = 1'b1;
    repeat (15) tick();
    check("w_15", bus4.BubbleCnt, 64'd15);
    tick();
    check("w_16", bus4.BubbleCnt, 64'd0);
    tick();
    check("w_17", bus4.BubbleCnt, 64'd1);
    check("w_stall", bus4.StallCnt, 64'd0);
    bus4.clear = 1'b0; bus4.en = 1'b0;
    repeat (17) tick();
    check("w_stall17", bus4.StallCnt, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
